cast_output_stage: RTL and testbench

CAST_OUTPUT_STAGE -- requirements
Module: cast_output_stage

---
 rtl/cast_pkg.sv | 42 ++++
 rtl/cast_skid_buffer.sv | 81 ++++++++
 rtl/cast_output_stage.sv | 147 ++++++++++++++
 tb/tb_cast_output_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cast_pkg.sv
//------------------------------------------------------------------------------
// cast_pkg
// Shared types and constants for the CAST router output path: flit type
// encoding, output-stage packet FSM states and the credit counter width.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DW
`define DW 32
`endif
`ifndef CAST_ROUTER_BUFFER_DEPTH_LOG
`define CAST_ROUTER_BUFFER_DEPTH_LOG 2
`endif

package cast_pkg;

  // Flit type, carried in the two most significant bits of every flit
  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  // Packet tracking state of an output stage
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } pkt_state_t;

  // Width of the exported credit counter
  localparam int CREDIT_W = 16;

  // Extract the flit type field from a flit
  function automatic flit_type_t get_flit_type(input logic [`DW-1:0] flit);
    return flit_type_t'(flit[`DW-1:`DW-2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cast_skid_buffer.sv
//------------------------------------------------------------------------------
// cast_skid_buffer
// Two-entry in-order flit buffer. Entry 0 always holds the oldest flit and is
// presented on data_o. Push and pop in the same cycle are supported at any
// occupancy where each is legal.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cast_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             accept_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             fire_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occupancy_o
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  // Next entry contents and occupancy from the push/pop handshakes
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    occ_d    = occ_q;
    // Guard against illegal handshakes so the buffer can never corrupt itself
    do_push  = accept_i & (occ_q != 2'd2);
    do_pop   = fire_i & (occ_q != 2'd0);
    case ({do_push, do_pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          entry0_d = data_i;
        end else begin
          entry1_d = data_i;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        occ_d    = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new flit lands behind whatever remains
        if (occ_q == 2'd1) begin
          entry0_d = data_i;
        end else begin
          entry0_d = entry1_q;
          entry1_d = data_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Buffer state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry0_q <= '0;
      entry1_q <= '0;
      occ_q    <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      occ_q    <= occ_d;
    end
  end

  assign data_o      = entry0_q;
  assign occupancy_o = occ_q;

endmodule

`default_nettype wire

// File: rtl/cast_output_stage.sv
//------------------------------------------------------------------------------
// cast_output_stage
// Router output stage: buffers crossbar flits in a two-entry skid buffer,
// gates the link with a downstream credit counter, tracks packet framing to
// flag protocol errors and pulses vc_release_o when a packet leaves.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cast_output_stage
  import cast_pkg::*;
#(
  parameter int CREDIT_MAX = 2**`CAST_ROUTER_BUFFER_DEPTH_LOG,
  parameter int isFC       = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [`DW-1:0]      data_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic [`DW-1:0]      data_o,
  input  logic                ready_i,
  input  logic                credit_i,
  output logic                vc_release_o,
  output logic [CREDIT_W-1:0] credit_cnt_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX_C = CREDIT_W'(CREDIT_MAX);
  localparam logic                FC_PORT      = (isFC != 0);

  logic [1:0]          occupancy;
  logic [`DW-1:0]      head_flit;
  logic                accept;
  logic                fire;
  flit_type_t          head_type;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  pkt_state_t          state_q, state_d;
  logic                err_q, err_d;
  logic                release_q, release_d;
  logic                proto_err;
  logic                credit_ovf;

  // Ready depends on registered occupancy only, so no combinational path
  // from ready_i back to ready_o exists.
  assign ready_o = (occupancy != 2'd2);
  assign accept  = valid_i & ready_o;
  assign valid_o = (occupancy != 2'd0) & (credit_q != '0);
  assign fire    = valid_o & ready_i;
  assign data_o  = head_flit;
  assign head_type = get_flit_type(head_flit);

  cast_skid_buffer #(
    .WIDTH (`DW)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .accept_i    (accept),
    .data_i      (data_i),
    .fire_i      (fire),
    .data_o      (head_flit),
    .occupancy_o (occupancy)
  );

  // Credit counter: consume on fire, return on credit_i, saturate at max
  always_comb begin
    credit_d   = credit_q;
    credit_ovf = 1'b0;
    case ({fire, credit_i})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CREDIT_MAX_C) begin
          credit_ovf = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Packet FSM next state; framing violations flag an error and hold state
  always_comb begin
    state_d   = state_q;
    proto_err = 1'b0;
    if (fire) begin
      case (state_q)
        ST_IDLE: begin
          case (head_type)
            FLIT_HEAD:   state_d = ST_BUSY;
            FLIT_SINGLE: state_d = ST_IDLE;
            // FC streams carry no headers, so a bare BODY/TAIL is legal there
            default:     proto_err = ~FC_PORT;
          endcase
        end
        ST_BUSY: begin
          case (head_type)
            FLIT_BODY: state_d = ST_BUSY;
            FLIT_TAIL: state_d = ST_IDLE;
            default:   proto_err = 1'b1;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sticky error and end-of-packet release pulse
  always_comb begin
    err_d     = err_q | proto_err | credit_ovf;
    release_d = fire & ((head_type == FLIT_TAIL) | (head_type == FLIT_SINGLE));
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Credit, error and release registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q  <= CREDIT_MAX_C;
      err_q     <= 1'b0;
      release_q <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      err_q     <= err_d;
      release_q <= release_d;
    end
  end

  assign credit_cnt_o = credit_q;
  assign busy_o       = (state_q == ST_BUSY);
  assign err_o        = err_q;
  assign vc_release_o = release_q;

endmodule

`default_nettype wire

// File: tb/tb_cast_output_stage.sv
//------------------------------------------------------------------------------
// tb_cast_output_stage
// Directed self-checking bench for cast_output_stage. Three instances share
// the stimulus: A (CREDIT_MAX=4, isFC=0), B (CREDIT_MAX=2, isFC=0) and
// C (CREDIT_MAX=4, isFC=1). Each task checks only the instance it targets.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DW
`define DW 32
`endif
`ifndef CAST_ROUTER_BUFFER_DEPTH_LOG
`define CAST_ROUTER_BUFFER_DEPTH_LOG 2
`endif

module tb_cast_output_stage;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic valid_i = 1'b0;
  logic [`DW-1:0] data_i = '0;
  logic ready_i = 1'b0;
  logic credit_i = 1'b0;

  logic ready_a, valid_a, vc_a, busy_a, err_a;
  logic [`DW-1:0] data_a;
  logic [15:0] cnt_a;
  logic ready_b, valid_b, vc_b, busy_b, err_b;
  logic [`DW-1:0] data_b;
  logic [15:0] cnt_b;
  logic ready_c, valid_c, vc_c, busy_c, err_c;
  logic [`DW-1:0] data_c;
  logic [15:0] cnt_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cast_output_stage #(.CREDIT_MAX(4), .isFC(0)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_a), .valid_o(valid_a), .data_o(data_a), .ready_i(ready_i),
    .credit_i(credit_i), .vc_release_o(vc_a), .credit_cnt_o(cnt_a),
    .busy_o(busy_a), .err_o(err_a));

  cast_output_stage #(.CREDIT_MAX(2), .isFC(0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_b), .valid_o(valid_b), .data_o(data_b), .ready_i(ready_i),
    .credit_i(credit_i), .vc_release_o(vc_b), .credit_cnt_o(cnt_b),
    .busy_o(busy_b), .err_o(err_b));

  cast_output_stage #(.CREDIT_MAX(4), .isFC(1)) dut_c (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_c), .valid_o(valid_c), .data_o(data_c), .ready_i(ready_i),
    .credit_i(credit_i), .vc_release_o(vc_c), .credit_cnt_o(cnt_c),
    .busy_o(busy_c), .err_o(err_c));

  function automatic logic [`DW-1:0] mk(input logic [1:0] t, input int p);
    logic [`DW-3:0] pl;
    pl = (`DW-2)'(p);
    return {t, pl};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0; credit_i = 1'b0;
    tick; tick;
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; valid_i = 1'b1; data_i = mk(2'b00, 5); ready_i = 1'b1; credit_i = 1'b0;
    tick; tick;
    checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
    checks++; if (data_a !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_a); end
    checks++; if (cnt_a !== 16'd4) begin failures++; $display("FAIL reset_credit got=%0d exp=4", cnt_a); end
    checks++; if ({vc_a, busy_a, err_a} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {vc_a, busy_a, err_a}); end
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_a); end
  endtask

  task automatic test_packet;
    logic [`DW-1:0] f [4];
    f[0] = mk(2'b00, 'h11); f[1] = mk(2'b01, 'h22); f[2] = mk(2'b01, 'h33); f[3] = mk(2'b10, 'h44);
    do_reset;
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = f[0];
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid_a !== 1'b1 || data_a !== f[i]) begin
        failures++; $display("FAIL pkt_out%0d got=%b/%h exp=1/%h", i, valid_a, data_a, f[i]);
      end
      if (i < 3) data_i = f[i+1]; else valid_i = 1'b0;
      tick;
      if (i == 1) begin
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL pkt_busy got=%b exp=1", busy_a); end
      end
    end
    checks++; if (vc_a !== 1'b1) begin failures++; $display("FAIL pkt_release got=%b exp=1", vc_a); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("FAIL pkt_credit got=%0d exp=0", cnt_a); end
    checks++; if ({err_a, busy_a, valid_a} !== 3'b000) begin failures++; $display("FAIL pkt_end_flags got=%b exp=000", {err_a, busy_a, valid_a}); end
    tick;
    checks++; if (vc_a !== 1'b0) begin failures++; $display("FAIL pkt_release_single got=%b exp=0", vc_a); end
  endtask

  task automatic test_credit_stall;
    logic [`DW-1:0] f [4];
    int sent, fired;
    logic acc, fr;
    for (int i = 0; i < 4; i++) f[i] = mk(2'b11, 'h100 + i);
    do_reset;
    ready_i = 1'b1; sent = 0; fired = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      valid_i = (sent < 4);
      data_i = (sent < 4) ? f[sent] : '0;
      acc = valid_i & ready_b;
      fr = valid_b & ready_i;
      if (fr) begin
        checks++; if (data_b !== f[fired]) begin failures++; $display("FAIL stall_order%0d got=%h exp=%h", fired, data_b, f[fired]); end
        fired++;
      end
      tick;
      if (acc) sent++;
    end
    valid_i = 1'b0;
    checks++; if (fired !== 2) begin failures++; $display("FAIL stall_fired got=%0d exp=2", fired); end
    checks++; if (sent !== 4) begin failures++; $display("FAIL stall_accepted got=%0d exp=4", sent); end
    checks++; if (valid_b !== 1'b0) begin failures++; $display("FAIL stall_valid got=%b exp=0", valid_b); end
    checks++; if (ready_b !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b exp=0", ready_b); end
    credit_i = 1'b1;
    tick;
    credit_i = 1'b0;
    fired = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (valid_b & ready_i) begin
        if (fired == 0) begin
          checks++; if (data_b !== f[2]) begin failures++; $display("FAIL stall_release_data got=%h exp=%h", data_b, f[2]); end
        end
        fired++;
      end
      tick;
    end
    checks++; if (fired !== 1) begin failures++; $display("FAIL stall_one_credit got=%0d exp=1", fired); end
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL stall_ready_after got=%b exp=1", ready_b); end
  endtask

  task automatic test_credit_simul;
    do_reset;
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = mk(2'b11, 1);
    tick;
    data_i = mk(2'b11, 2);
    tick;
    valid_i = 1'b0; credit_i = 1'b1;
    checks++; if (cnt_a !== 16'd3 || valid_a !== 1'b1) begin failures++; $display("FAIL simul_pre got=%0d/%b exp=3/1", cnt_a, valid_a); end
    tick;
    credit_i = 1'b0;
    checks++; if (cnt_a !== 16'd3) begin failures++; $display("FAIL simul_credit got=%0d exp=3", cnt_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL simul_err got=%b exp=0", err_a); end
  endtask

  task automatic test_credit_overflow;
    do_reset;
    credit_i = 1'b1;
    tick;
    credit_i = 1'b0;
    checks++; if (cnt_a !== 16'd4) begin failures++; $display("FAIL ovf_credit got=%0d exp=4", cnt_a); end
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", err_a); end
    for (int i = 0; i < 5; i++) tick;
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL ovf_err_sticky got=%b exp=1", err_a); end
    do_reset;
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL ovf_err_cleared got=%b exp=0", err_a); end
  endtask

  task automatic test_fc_body;
    do_reset;
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = mk(2'b01, 'h55);
    tick;
    valid_i = 1'b0;
    checks++; if (valid_a !== 1'b1 || data_a !== mk(2'b01, 'h55)) begin failures++; $display("FAIL body_fwd_nonfc got=%b/%h", valid_a, data_a); end
    checks++; if (valid_c !== 1'b1 || data_c !== mk(2'b01, 'h55)) begin failures++; $display("FAIL body_fwd_fc got=%b/%h", valid_c, data_c); end
    tick;
    checks++; if (err_a !== 1'b1) begin failures++; $display("FAIL body_err_nonfc got=%b exp=1", err_a); end
    checks++; if (err_c !== 1'b0) begin failures++; $display("FAIL body_err_fc got=%b exp=0", err_c); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL body_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_reset_mid_packet;
    int pulses, valids;
    do_reset;
    ready_i = 1'b1; valid_i = 1'b1; data_i = mk(2'b00, 1);
    tick;
    data_i = mk(2'b01, 2);
    tick;
    ready_i = 1'b0; data_i = mk(2'b10, 3);
    tick;
    valid_i = 1'b0;
    checks++; if (busy_a !== 1'b1 || ready_a !== 1'b0) begin failures++; $display("FAIL mid_pre got=%b%b exp=10", busy_a, ready_a); end
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0; ready_i = 1'b1;
    pulses = 0; valids = 0;
    for (int i = 0; i < 4; i++) begin
      pulses += int'(vc_a); valids += int'(valid_a);
      tick;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_release got=%0d exp=0", pulses); end
    checks++; if (valids !== 0) begin failures++; $display("FAIL mid_valid got=%0d exp=0", valids); end
    checks++; if (busy_a !== 1'b0 || ready_a !== 1'b1) begin failures++; $display("FAIL mid_post got=%b%b exp=01", busy_a, ready_a); end
  endtask

  task automatic test_back_to_back;
    int sent, recv, pulses, cyc, bad;
    logic acc, fr, prev_fire;
    do_reset;
    sent = 0; recv = 0; pulses = 0; cyc = 0; bad = 0; prev_fire = 1'b0;
    while (recv < 200 && cyc < 5000) begin
      ready_i = 1'($urandom_range(0, 1));
      valid_i = (sent < 200);
      data_i = mk(2'b11, sent);
      credit_i = prev_fire;
      acc = valid_i & ready_a;
      fr = valid_a & ready_i;
      if (vc_a) pulses++;
      if (fr) begin
        if (data_a !== mk(2'b11, recv)) bad++;
        recv++;
      end
      tick;
      prev_fire = fr;
      if (acc) sent++;
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b0; credit_i = prev_fire;
    for (int i = 0; i < 3; i++) begin
      if (vc_a) pulses++;
      tick;
      credit_i = 1'b0;
    end
    checks++; if (recv !== 200) begin failures++; $display("FAIL b2b_received got=%0d exp=200 (cycles=%0d)", recv, cyc); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_order got=%0d out-of-order exp=0", bad); end
    checks++; if (pulses !== 200) begin failures++; $display("FAIL b2b_release got=%0d exp=200", pulses); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", err_a); end
  endtask

  initial begin
    test_reset;
    test_packet;
    test_credit_stall;
    test_credit_simul;
    test_credit_overflow;
    test_fc_body;
    test_reset_mid_packet;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
